// File: rtl/stage_sequencer_if.sv
// stage_sequencer_if: controller-to-countdown-timer handshake bundle
interface stage_sequencer_if;
  logic [1:0] seconds;
  logic next_stage;
  logic start_countdown;
  logic timer_rst_n;
  modport master(input seconds, next_stage, output start_countdown, timer_rst_n);
  modport slave(output seconds, next_stage, input start_countdown, timer_rst_n);
endinterface

// File: rtl/stage_sequencer.sv
// stage_sequencer: steps a game through NUM_STAGES countdowns of a latching 3 s timer with watchdog and 7-seg display
module stage_sequencer #(
  parameter int NUM_STAGES = 4,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic game_start,
  stage_sequencer_if.master tif,
  output logic [2:0] stage,
  output logic [6:0] seg,
  output logic busy,
  output logic done,
  output logic error
);
  localparam logic [2:0] IDLE = 3'd0, ARM = 3'd1, WAIT = 3'd2, REARM = 3'd3, DONE = 3'd4, FAULT = 3'd5;
  localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WD_LIM = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST = 3'(NUM_STAGES - 1);

  logic [2:0] state, state_n;
  logic [WW-1:0] wd;
  logic game_start_q, start_edge;

  assign start_edge = game_start & ~game_start_q;

  function automatic logic [6:0] seg_of(input logic [1:0] s);
    return s == 2'd3 ? 7'b0000110 : s == 2'd2 ? 7'b0010010 : s == 2'd1 ? 7'b1001111 : 7'b0000001;
  endfunction

  // next_stage beats the watchdog when both land on the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start_edge ? ARM : state;
      ARM:        state_n = WAIT;
      WAIT:       state_n = tif.next_stage ? REARM : wd == WD_LIM ? FAULT : WAIT;
      REARM:      state_n = stage == LAST ? DONE : ARM;
      FAULT:      state_n = FAULT;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      game_start_q <= 1'b0;
      wd <= '0;
      stage <= '0;
      tif.start_countdown <= 1'b0;
      tif.timer_rst_n <= 1'b0;
      seg <= 7'b1111111;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      game_start_q <= game_start;
      wd <= state != WAIT ? '0 : wd == WD_LIM ? wd : wd + 1'b1;
      stage <= (state inside {IDLE, DONE}) && start_edge ? 3'd0 :
               state == REARM && stage != LAST ? stage + 3'd1 : stage;
      tif.start_countdown <= state == ARM;
      tif.timer_rst_n <= !(state inside {REARM, FAULT});
      seg <= (state inside {ARM, WAIT}) ? seg_of(tif.seconds) : state == FAULT ? 7'b0110000 : 7'b1111111;
      busy <= state inside {ARM, WAIT, REARM};
      done <= state == DONE;
      error <= state == FAULT;
    end
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of stage_sequencer against a small latching countdown timer model
module tb_stage_sequencer;
  localparam int SEC = 3;
  logic clk = 0, reset = 1, game_start = 0, manual = 0, ns_man = 0;
  logic [2:0] stage;
  logic [6:0] seg;
  logic busy, done, error;
  logic [1:0] sec = 2'd3;
  logic ns_m = 0, run = 0;
  int div = 0;
  int cmp = 0, bad = 0;

  stage_sequencer_if tif();
  assign tif.seconds = sec;
  assign tif.next_stage = manual ? ns_man : ns_m;

  stage_sequencer #(.NUM_STAGES(4), .TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .game_start(game_start), .tif(tif),
    .stage(stage), .seg(seg), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!tif.timer_rst_n) begin
      sec <= 2'd3; ns_m <= 1'b0; run <= 1'b0; div <= 0;
    end else if (tif.start_countdown) begin
      run <= 1'b1; div <= 0;
    end else if (run) begin
      if (div == SEC - 1) begin
        div <= 0;
        if (sec == 2'd1) begin sec <= 2'd0; ns_m <= 1'b1; run <= 1'b0; end
        else sec <= sec - 2'd1;
      end else div <= div + 1;
    end

  function automatic logic [6:0] dec(input logic [1:0] s);
    case (s)
      2'd3: dec = 7'b0000110;
      2'd2: dec = 7'b0010010;
      2'd1: dec = 7'b1001111;
      default: dec = 7'b0000001;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1; game_start = 0; manual = 0; ns_man = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic wait_start();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = tif.start_countdown;
    end
    cmp++;
    if (!got) begin bad++; $display("FAIL wait_start: start_countdown got 0 want 1 within 20 cycles"); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    #1;
    cmp++;
    if ({tif.start_countdown, tif.timer_rst_n, stage, seg, busy, done, error} !== {2'b00, 3'd0, 7'h7f, 3'b000}) begin
      bad++; $display("FAIL reset_vals: got %h want %h", {tif.start_countdown, tif.timer_rst_n, stage, seg, busy, done, error}, {2'b00, 3'd0, 7'h7f, 3'b000});
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    cmp++;
    if ({tif.timer_rst_n, seg, busy} !== {1'b1, 7'h7f, 1'b0}) begin
      bad++; $display("FAIL idle_vals: got %h want %h", {tif.timer_rst_n, seg, busy}, {1'b1, 7'h7f, 1'b0});
    end
  endtask

  task automatic test_first_start();
    game_start = 1;
    @(negedge clk);
    cmp++;
    if (tif.start_countdown !== 1'b0) begin bad++; $display("FAIL start_early: got %b want 0", tif.start_countdown); end
    @(negedge clk);
    cmp++;
    if ({tif.start_countdown, busy, stage, seg} !== {2'b11, 3'd0, 7'b0000110}) begin
      bad++; $display("FAIL start_pulse: got %h want %h", {tif.start_countdown, busy, stage, seg}, {2'b11, 3'd0, 7'b0000110});
    end
    @(negedge clk);
    cmp++;
    if (tif.start_countdown !== 1'b0) begin bad++; $display("FAIL start_width: got %b want 0", tif.start_countdown); end
  endtask

  task automatic test_full_game();
    int pulses = 1, rst_low = 0, seg_bad = 0;
    bit seen_two = 0;
    logic [11:0] log = 12'd0;
    logic [1:0] prev = sec;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (tif.start_countdown) begin
        if (pulses < 4) log[3*pulses +: 3] = stage;
        pulses++;
      end
      if (!tif.timer_rst_n) rst_low++;
      if (seg !== 7'h7f && seg !== dec(prev)) seg_bad++;
      if (seg === 7'b0010010) seen_two = 1;
      prev = sec;
    end
    cmp++;
    if (done !== 1'b1) begin bad++; $display("FAIL game_done: got %b want 1 within 300 cycles", done); end
    cmp++;
    if (pulses != 4) begin bad++; $display("FAIL start_count: got %0d want 4", pulses); end
    cmp++;
    if (rst_low != 4) begin bad++; $display("FAIL rearm_low_cycles: got %0d want 4", rst_low); end
    cmp++;
    if (log !== 12'o3210) begin bad++; $display("FAIL stage_seq: got %o want 3210", log); end
    cmp++;
    if (seg_bad != 0 || !seen_two) begin bad++; $display("FAIL seg_track: got %0d bad/seen2=%b want 0/1", seg_bad, seen_two); end
    repeat (3) @(negedge clk);
    cmp++;
    if ({done, busy, stage, seg, tif.timer_rst_n} !== {2'b10, 3'd3, 7'h7f, 1'b1}) begin
      bad++; $display("FAIL done_hold: got %h want %h", {done, busy, stage, seg, tif.timer_rst_n}, {2'b10, 3'd3, 7'h7f, 1'b1});
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    manual = 1;
    game_start = 1;
    wait_start();
    repeat (19) @(negedge clk);
    cmp++;
    if (error !== 1'b0) begin bad++; $display("FAIL fault_early: got %b want 0", error); end
    repeat (2) @(negedge clk);
    cmp++;
    if ({error, seg, tif.timer_rst_n, busy} !== {1'b1, 7'b0110000, 2'b00}) begin
      bad++; $display("FAIL fault_vals: got %h want %h", {error, seg, tif.timer_rst_n, busy}, {1'b1, 7'b0110000, 2'b00});
    end
    game_start = 0;
    @(negedge clk);
    game_start = 1;
    repeat (6) begin @(negedge clk); if (tif.start_countdown) n++; end
    cmp++;
    if ({n[3:0], error, tif.timer_rst_n, stage} !== {4'd0, 2'b10, 3'd0}) begin
      bad++; $display("FAIL fault_sticky: got %h want %h", {n[3:0], error, tif.timer_rst_n, stage}, {4'd0, 2'b10, 3'd0});
    end
    do_reset();
    cmp++;
    if ({error, tif.timer_rst_n, seg} !== {2'b01, 7'h7f}) begin
      bad++; $display("FAIL fault_exit: got %h want %h", {error, tif.timer_rst_n, seg}, {2'b01, 7'h7f});
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    do_reset();
    manual = 1;
    game_start = 1;
    wait_start();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      game_start = ~game_start;
      if (tif.start_countdown) n++;
    end
    @(negedge clk);
    if (tif.start_countdown) n++;
    cmp++;
    if ({n[3:0], stage, busy, error} !== {4'd0, 3'd0, 2'b10}) begin
      bad++; $display("FAIL toggle_ignored: got %h want %h", {n[3:0], stage, busy, error}, {4'd0, 3'd0, 2'b10});
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    manual = 1;
    game_start = 1;
    wait_start();
    repeat (19) @(negedge clk);
    ns_man = 1;
    repeat (2) @(negedge clk);
    cmp++;
    if ({tif.timer_rst_n, error} !== 2'b00) begin
      bad++; $display("FAIL tie_rearm: got %b want 00", {tif.timer_rst_n, error});
    end
    ns_man = 0;
    @(negedge clk);
    cmp++;
    if ({tif.start_countdown, stage, error} !== {1'b1, 3'd1, 1'b0}) begin
      bad++; $display("FAIL tie_next: got %h want %h", {tif.start_countdown, stage, error}, {1'b1, 3'd1, 1'b0});
    end
  endtask

  task automatic test_mid_reset();
    bit hit = 0;
    do_reset();
    game_start = 1;
    for (int i = 0; i < 200 && !hit; i++) begin @(negedge clk); hit = stage == 3'd2; end
    repeat (4) @(negedge clk);
    cmp++;
    if ({stage, busy} !== {3'd2, 1'b1}) begin
      bad++; $display("FAIL reach_stage2: got %h want %h", {stage, busy}, {3'd2, 1'b1});
    end
    reset = 1;
    #1;
    cmp++;
    if ({tif.start_countdown, tif.timer_rst_n, stage, seg, busy, done, error} !== {2'b00, 3'd0, 7'h7f, 3'b000}) begin
      bad++; $display("FAIL async_reset: got %h want %h", {tif.start_countdown, tif.timer_rst_n, stage, seg, busy, done, error}, {2'b00, 3'd0, 7'h7f, 3'b000});
    end
    game_start = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    game_start = 1;
    wait_start();
    cmp++;
    if ({stage, busy, seg} !== {3'd0, 1'b1, 7'b0000110}) begin
      bad++; $display("FAIL restart: got %h want %h", {stage, busy, seg}, {3'd0, 1'b1, 7'b0000110});
    end
  endtask

  initial begin
    test_reset();
    test_first_start();
    test_full_game();
    test_timeout();
    test_back_to_back();
    test_same_cycle();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Drives the 3-second countdown timer from the controller side of its interface.
- Issues the start_countdown request and monitors seconds and next_stage.
- Re-arms the timer between stages, because the timer latches in its terminal state until reset.
- Steps the game through NUM_STAGES stages and drives a single 7-segment digit showing the remaining seconds.

Parameters:
- NUM_STAGES, 4, number of countdown stages per game (legal range 1..8).
- TIMEOUT_CYCLES, 5000000, watchdog limit in clk cycles for next_stage to arrive after start (5 s at 1 MHz).

Ports:
- clk  input  1  system clock (1 MHz).
- reset  input  1  asynchronous, active-high reset.
- game_start  input  1  level from button logic; its rising edge begins a game.
- seconds  input  2  remaining seconds from the timer (3..0).
- next_stage  input  1  timer terminal flag; stays high until the timer is reset.
- start_countdown  output  1  one-cycle start request to the timer.
- timer_rst_n  output  1  active-low reset to the timer.
- stage  output  3  current stage index, 0..NUM_STAGES-1.
- seg  output  7  active-low segments {a,b,c,d,e,f,g}; seg[6] is segment a.
- busy  output  1  high in ARM, WAIT and REARM.
- done  output  1  high in DONE.
- error  output  1  high in FAULT.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-high.
  - All state updates occur on posedge clk.
- Reset values:
  - state=IDLE, start_countdown=0, timer_rst_n=0 (holds the timer in reset), stage=0.
  - seg=7'b1111111 (blank), busy=0, done=0, error=0.
  - Edge-detect register = 0; watchdog = 0.
- Edge detect: game_start is registered once; start_edge = game_start & ~game_start_q.
- Output registration: all outputs are registered; state-driven outputs follow the state with 1-cycle latency.
- FSM states: IDLE, ARM, WAIT, REARM, DONE, FAULT.
- IDLE:
  - Drives timer_rst_n=1 and start_countdown=0.
  - On start_edge: stage<=0, go to ARM.
- ARM:
  - Drives start_countdown=1 for exactly one cycle.
  - Clears the watchdog, then goes to WAIT.
- WAIT:
  - If next_stage=1: go to REARM.
  - Otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 with next_stage still 0: go to FAULT.
  - If next_stage=1 on the same cycle the watchdog reaches its limit, next_stage wins and the state goes to REARM.
- REARM:
  - Drives timer_rst_n=0 for exactly one cycle.
  - If stage==NUM_STAGES-1: go to DONE.
  - Otherwise stage<=stage+1 and go to ARM; the next start_countdown pulse follows with timer_rst_n back at 1.
- DONE:
  - done=1 and timer_rst_n=1; stage holds NUM_STAGES-1.
  - On start_edge: stage<=0, go to ARM (new game).
- FAULT:
  - error=1 and timer_rst_n=0 held continuously.
  - start_edge is ignored; FAULT exits only via reset.
- start_edge handling:
  - Ignored in ARM, WAIT, REARM and FAULT; it is not queued.
- next_stage handling:
  - Sampled only in WAIT; ignored in all other states.
- Watchdog:
  - Width is $clog2(TIMEOUT_CYCLES).
  - Saturates rather than wrapping.
  - Cleared in every state except WAIT.
- Display (seg), registered:
  - In ARM or WAIT, seg decodes seconds: 3→0000110, 2→0010010, 1→1001111, 0→0000001.
  - In FAULT, seg shows "E" = 0110000.
  - In IDLE, REARM and DONE, seg is blank = 1111111.
- Reset mid-operation: all registers return to their reset values immediately, and timer_rst_n=0 resets the timer with them.

Test Plan:
- Reset, then release; pulse game_start 0→1 → exactly one start_countdown cycle 2 cycles after the edge; busy=1; stage=0; seg=0000110 while seconds=3.
- Timer model counts 3→0 and raises next_stage, with NUM_STAGES=4 → timer_rst_n low exactly 1 cycle per stage; stage steps 0,1,2,3; 4 start pulses total; then done=1 and seg=1111111.
- next_stage held at 0, with TIMEOUT_CYCLES=20 → error=1 and seg=0110000 at cycle 20 of WAIT; timer_rst_n stays 0; a game_start edge has no effect; reset returns to IDLE.
- game_start toggled repeatedly during WAIT → no extra start_countdown pulses; stage unchanged.
- next_stage rises on the same cycle the watchdog hits its limit → REARM taken; error stays 0.
- Reset asserted mid-WAIT at stage=2 → all outputs return to reset values asynchronously; a following game_start edge restarts at stage=0.
